// File: rtl/bullet_hit_scanner.sv
// bullet_hit_scanner: per-frame bullet/enemy box collision scan with hit pulses and a saturating score
module bullet_hit_scanner #(
  parameter int NUM_BULLETS = 30,
  parameter int NUM_ENEMIES = 8,
  parameter int BULLET_W    = 4,
  parameter int BULLET_H    = 8,
  parameter int ENEMY_W     = 32,
  parameter int ENEMY_H     = 32,
  parameter int SCORE_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [20*NUM_BULLETS-1:0] bullet_pos,
  input  logic [20*NUM_ENEMIES-1:0] enemy_pos,
  input  logic [NUM_ENEMIES-1:0]   enemy_alive,
  output logic [NUM_BULLETS-1:0]   collided,
  output logic [NUM_ENEMIES-1:0]   enemy_killed,
  output logic [SCORE_W-1:0]       score,
  output logic                     busy
);
  localparam int BW = $clog2(NUM_BULLETS);
  localparam int EW = $clog2(NUM_ENEMIES);
  localparam int PW = $clog2(NUM_ENEMIES + 1);
  typedef enum logic [1:0] {IDLE, SNAP, SCAN, REPORT} state_t;
  state_t state;
  logic [20*NUM_BULLETS-1:0] sb;
  logic [20*NUM_ENEMIES-1:0] se;
  logic [NUM_ENEMIES-1:0] sa;
  logic [BW-1:0] bi;
  logic [EW-1:0] ej;
  logic [NUM_BULLETS-1:0] hit_b, hb_n;
  logic [NUM_ENEMIES-1:0] hit_e, he_n;
  logic [19:0] b, e;
  logic [10:0] bx, by, ex, ey;
  logic hit, last_j, last;
  logic [PW-1:0] pop;
  logic [SCORE_W+PW-1:0] sum;
  always_comb begin
    b = sb[20*bi +: 20];
    e = se[20*ej +: 20];
    bx = {1'b0, b[19:10]};
    by = {1'b0, b[9:0]};
    ex = {1'b0, e[19:10]};
    ey = {1'b0, e[9:0]};
    // 11-bit sums keep the far edge of a box near x/y=1023 from wrapping
    hit = (b[9:0] != 10'h3FF) && sa[ej] && !hit_b[bi] && !hit_e[ej] &&
          (bx < ex + 11'(ENEMY_W)) && (ex < bx + 11'(BULLET_W)) &&
          (by < ey + 11'(ENEMY_H)) && (ey < by + 11'(BULLET_H));
    hb_n = hit_b | (NUM_BULLETS'(hit) << bi);
    he_n = hit_e | (NUM_ENEMIES'(hit) << ej);
    pop = '0;
    for (int k = 0; k < NUM_ENEMIES; k++) pop = pop + PW'(he_n[k]);
    sum = (SCORE_W+PW)'(score) + (SCORE_W+PW)'(pop);
    last_j = ej == EW'(NUM_ENEMIES - 1);
    last = last_j && (bi == BW'(NUM_BULLETS - 1));
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sb <= '0;
      se <= '0;
      sa <= '0;
      bi <= '0;
      ej <= '0;
      hit_b <= '0;
      hit_e <= '0;
      collided <= '0;
      enemy_killed <= '0;
      score <= '0;
      busy <= 1'b0;
    end else begin
      collided <= '0;
      enemy_killed <= '0;
      case (state)
        IDLE: if (frame_tick) begin
          state <= SNAP;
          busy <= 1'b1;
        end
        SNAP: begin
          sb <= bullet_pos;
          se <= enemy_pos;
          sa <= enemy_alive;
          hit_b <= '0;
          hit_e <= '0;
          bi <= '0;
          ej <= '0;
          state <= SCAN;
        end
        SCAN: begin
          hit_b <= hb_n;
          hit_e <= he_n;
          // the final pair's hit is folded straight into the report outputs
          if (last) begin
            state <= REPORT;
            collided <= hb_n;
            enemy_killed <= he_n;
            score <= |sum[SCORE_W+PW-1:SCORE_W] ? '1 : sum[SCORE_W-1:0];
          end else if (last_j) begin
            ej <= '0;
            bi <= bi + 1'b1;
          end else ej <= ej + 1'b1;
        end
        REPORT: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bullet_hit_scanner.sv
// tb_bullet_hit_scanner: directed checks of scan timing, hit rules, score and reset behaviour
module tb_bullet_hit_scanner;
  logic clock = 0, reset = 1, frame_tick = 0;
  logic [599:0] bullet_pos;
  logic [159:0] enemy_pos;
  logic [7:0] enemy_alive;
  logic [29:0] collided, s_collided;
  logic [7:0] enemy_killed, s_killed;
  logic [15:0] score;
  logic [2:0] s_score;
  logic busy, s_busy;
  int total = 0, bad = 0;
  int first_c, npulse, nbusy;
  logic [29:0] col_or;
  logic [7:0] kil_or;
  always #5 clock = ~clock;
  bullet_hit_scanner dut (.clock(clock), .reset(reset), .frame_tick(frame_tick),
    .bullet_pos(bullet_pos), .enemy_pos(enemy_pos), .enemy_alive(enemy_alive),
    .collided(collided), .enemy_killed(enemy_killed), .score(score), .busy(busy));
  // narrow-score twin sharing the same inputs, so saturation is reachable quickly
  bullet_hit_scanner #(.SCORE_W(3)) sat (.clock(clock), .reset(reset), .frame_tick(frame_tick),
    .bullet_pos(bullet_pos), .enemy_pos(enemy_pos), .enemy_alive(enemy_alive),
    .collided(s_collided), .enemy_killed(s_killed), .score(s_score), .busy(s_busy));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_all();
    for (int i = 0; i < 30; i++) bullet_pos[20*i +: 20] = {10'd0, 10'h3FF};
    enemy_pos = '0;
    enemy_alive = '0;
  endtask
  task automatic set_b(input int i, input int x, input int y);
    bullet_pos[20*i +: 20] = {10'(x), 10'(y)};
  endtask
  task automatic set_e(input int j, input int x, input int y, input logic alive);
    enemy_pos[20*j +: 20] = {10'(x), 10'(y)};
    enemy_alive[j] = alive;
  endtask
  task automatic run(input int retick, input int rst_at);
    first_c = 0; npulse = 0; nbusy = 0; col_or = '0; kil_or = '0;
    @(posedge clock); #1 frame_tick = 1;
    @(posedge clock); #1 frame_tick = 0;
    for (int c = 1; c <= 250; c++) begin
      if (c > 1) begin @(posedge clock); #1; end
      frame_tick = (c == retick);
      if (c == rst_at + 1) reset = 0;
      if (c == rst_at) begin
        reset = 1;
        #1;
        check("rst_mid_collided", collided, 0);
        check("rst_mid_killed", enemy_killed, 0);
        check("rst_mid_busy", busy, 0);
      end
      if (busy) nbusy++;
      if (collided != 0 || enemy_killed != 0) begin
        npulse++;
        if (first_c == 0) first_c = c;
        col_or |= collided;
        kil_or |= enemy_killed;
      end
    end
  endtask
  task automatic geo1(input int bx, input logic alive);
    clear_all();
    set_b(0, bx, 200);
    set_e(0, 90, 180, alive);
  endtask
  initial begin
    clear_all();
    #1;
    check("rst_collided", collided, 0);
    check("rst_killed", enemy_killed, 0);
    check("rst_score", score, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1 reset = 0;
    geo1(100, 1); run(0, 0);
    check("t1_first", first_c, 242); check("t1_npulse", npulse, 1);
    check("t1_col", col_or, 30'h1); check("t1_kill", kil_or, 8'h1);
    check("t1_score", score, 1); check("t1_busy", nbusy, 242);
    geo1(122, 1); run(0, 0);
    check("t2_edge_npulse", npulse, 0); check("t2_edge_score", score, 1);
    geo1(121, 1); run(0, 0);
    check("t2_in_col", col_or, 30'h1); check("t2_in_score", score, 2);
    clear_all();
    set_b(3, 310, 310); set_b(7, 305, 320);
    set_e(2, 300, 300, 1);
    run(0, 0);
    check("t3_col", col_or, 30'h8); check("t3_kill", kil_or, 8'h4);
    check("t3_npulse", npulse, 1); check("t3_score", score, 3);
    clear_all();
    set_b(0, 515, 510);
    set_e(4, 500, 500, 1); set_e(5, 510, 500, 1);
    run(0, 0);
    check("t3b_col", col_or, 30'h1); check("t3b_kill", kil_or, 8'h10);
    check("t3b_score", score, 4);
    geo1(100, 0); run(0, 0);
    check("t4_dead_npulse", npulse, 0); check("t4_dead_busy", nbusy, 242);
    clear_all();
    set_b(0, 1000, 1023);
    set_e(0, 990, 1000, 1);
    run(0, 0);
    check("t4_empty_npulse", npulse, 0); check("t4_empty_busy", nbusy, 242);
    check("t4_score", score, 4);
    clear_all();
    set_b(0, 10, 10); set_b(1, 110, 10); set_b(2, 210, 10);
    set_e(0, 0, 0, 1); set_e(1, 100, 0, 1); set_e(2, 200, 0, 1);
    run(0, 0);
    check("t6a_col", col_or, 30'h7); check("t6a_kill", kil_or, 8'h7);
    check("t6a_score", score, 7); check("t6a_sat", s_score, 7);
    run(0, 0);
    check("t6b_score", score, 10); check("t6b_sat", s_score, 7);
    geo1(100, 1); run(100, 0);
    check("t5_retick_first", first_c, 242); check("t5_retick_npulse", npulse, 1);
    check("t5_retick_busy", nbusy, 242); check("t5_retick_score", score, 11);
    run(0, 50);
    check("t5_rst_npulse", npulse, 0); check("t5_rst_busy", nbusy, 49);
    check("t5_rst_score", score, 0); check("t5_rst_sat", s_score, 0);
    run(0, 0);
    check("t5_fresh_first", first_c, 242); check("t5_fresh_score", score, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
